mem_bus_responder: RTL and testbench

- Slave-side model of the core's instruction/data memory bus. Answers req/gnt/err/rdata transactions from one core port (imem or dmem) using a word-addressed SRAM array.
- Grant latency is a fixed or pseudo-random number of wait states. Requests outside the mapped window complete with a bus error.
- Used in simulation and formal benches as the memory the core talks to; instantiated once per core memory port.

---
 rtl/mem_bus_responder.sv | 132 +++++++++++++
 tb/tb_mem_bus_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_bus_responder                                             |
// | Desc     : req/gnt/err/rdata memory-bus slave over a word-addressed SRAM; |
// |            `MEM_RESP_RAND_STALL_EN selects LFSR-randomised grant delay.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_bus_responder #(
  parameter int                    MEM_ADDR_W = 64,
  parameter int                    MEM_STRB_W = 8,
  parameter int                    MEM_DATA_W = 64,
  parameter int                    DEPTH_W    = 10,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    GNT_DELAY  = 2
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  mem_req,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_wen,
  input  logic [MEM_STRB_W-1:0] mem_strb,
  input  logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_gnt,
  output logic                  mem_err,
  output logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam int         c_BYTE_SH = $clog2(MEM_STRB_W);
  localparam logic [3:0] c_DELAY   = 4'(GNT_DELAY);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [3:0]            r_target;
  logic                  r_err;
  logic [MEM_DATA_W-1:0] r_rdata;
  logic [MEM_DATA_W-1:0] r_mem [0:(2**DEPTH_W)-1];

  logic [MEM_ADDR_W:0]   w_diff;
  logic [MEM_ADDR_W-1:0] w_offset;
  logic                  w_below;
  logic                  w_in_range;
  logic [DEPTH_W-1:0]    w_index;
  logic [3:0]            w_target;
  logic                  w_gnt;

  // Extra MSB of the subtraction is the borrow: set when the address is below the window.
  assign w_diff     = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign w_offset   = w_diff[MEM_ADDR_W-1:0];
  assign w_below    = w_diff[MEM_ADDR_W];
  assign w_in_range = !w_below && ((w_offset >> (c_BYTE_SH + DEPTH_W)) == '0);
  assign w_index    = w_offset[c_BYTE_SH +: DEPTH_W];

`ifdef MEM_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Right-shifting Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_lfsr <= 16'h0001;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_target = 4'({1'b0, r_lfsr[3:0]} % 5'(GNT_DELAY + 1));
`else
  assign w_target = c_DELAY;
`endif

  // Grant is combinational so a zero-delay target completes in the request cycle.
  assign w_gnt = !g_reset && mem_req &&
                 (((r_state == S_IDLE) && (w_target == 4'd0)) ||
                  ((r_state == S_WAIT) && (r_cnt == r_target)));

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_target <= 4'd0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_err <= w_gnt && !w_in_range;
      if (w_gnt && !mem_wen) begin
        r_rdata <= w_in_range ? r_mem[w_index] : '0;
      end
      case (r_state)
        S_IDLE: begin
          if (mem_req && (w_target != 4'd0)) begin
            r_state  <= S_WAIT;
            r_cnt    <= 4'd1;
            r_target <= w_target;
          end
        end
        S_WAIT: begin
          if (!mem_req || (r_cnt == r_target)) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Storage is intentionally unreset; contents survive g_reset.
  always_ff @(posedge g_clk) begin
    if (w_gnt && mem_wen && w_in_range) begin
      for (int i = 0; i < MEM_STRB_W; i++) begin
        if (mem_strb[i]) begin
          r_mem[w_index][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_gnt   = w_gnt;
  assign mem_err   = r_err;
  assign mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_bus_responder                                          |
// | Desc     : scoreboard bench: port 0 with wait states, port 1 zero-delay.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mem_bus_responder;

  localparam logic [63:0] BASE = 64'h1000;
`ifdef MEM_RESP_RAND_STALL_EN
  localparam int D0   = 3;
  localparam int NREQ = 1000;
`else
  localparam int D0   = 2;
  localparam int NREQ = 24;
`endif

  typedef struct {
    logic        rd;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req, wen;
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];
  logic [7:0]  strb  [2];
  logic        gnt0, gnt1, err0, err1;
  logic [63:0] rd0, rd1;

  exp_t        exp_q[$];
  logic [63:0] model   [2][1024];
  logic [63:0] last_rd [2];
  logic        pend    [2];
  logic [15:0] seen;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.BASE_ADDR(BASE), .GNT_DELAY(D0)) u_dut0 (
    .g_clk(clk), .g_reset(rst), .mem_req(req[0]), .mem_addr(addr[0]),
    .mem_wen(wen[0]), .mem_strb(strb[0]), .mem_wdata(wdata[0]),
    .mem_gnt(gnt0), .mem_err(err0), .mem_rdata(rd0));

  mem_bus_responder #(.BASE_ADDR(BASE), .GNT_DELAY(0)) u_dut1 (
    .g_clk(clk), .g_reset(rst), .mem_req(req[1]), .mem_addr(addr[1]),
    .mem_wen(wen[1]), .mem_strb(strb[1]), .mem_wdata(wdata[1]),
    .mem_gnt(gnt1), .mem_err(err1), .mem_rdata(rd1));

  function automatic logic obs_gnt(input int p);
    return (p == 0) ? gnt0 : gnt1;
  endfunction
  function automatic logic obs_err(input int p);
    return (p == 0) ? err0 : err1;
  endfunction
  function automatic logic [63:0] obs_rd(input int p);
    return (p == 0) ? rd0 : rd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: runs at every negedge sample point.
  task automatic mon();
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      check("gnt_without_req", 64'(obs_gnt(p) & ~req[p]), 64'd0);
      if (pend[p]) begin
        check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_err", 64'(obs_err(p)), 64'(e.err));
          if (e.rd) last_rd[p] = e.rdata;
          check("resp_rdata", obs_rd(p), last_rd[p]);
        end
      end else begin
        check("idle_err_low", 64'(obs_err(p)), 64'd0);
        check("rdata_hold", obs_rd(p), last_rd[p]);
      end
      pend[p] = obs_gnt(p);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sample();
      adv();
    end
  endtask

  task automatic push_exp(input int p, input logic [63:0] a, input logic w,
                          input logic [7:0] s, input logic [63:0] d);
    logic [63:0] off;
    logic        inr;
    int          idx;
    exp_t        e;
    off = a - BASE;
    inr = (a >= BASE) && ((off >> 3) < 64'd1024);
    idx = int'((off >> 3) & 64'd1023);
    e.rd    = !w;
    e.err   = !inr;
    e.rdata = (!w && inr) ? model[p][idx] : 64'd0;
    if (w && inr) begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) model[p][idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input int p, input logic [63:0] a, input logic w,
                       input logic [7:0] s, input logic [63:0] d);
    req[p] = 1'b1; addr[p] = a; wen[p] = w; strb[p] = s; wdata[p] = d;
  endtask

  // Full transaction: raise req, measure grant delay, drop req one cycle after gnt.
  task automatic do_req(input int p, input logic [63:0] a, input logic w,
                        input logic [7:0] s, input logic [63:0] d, input string tag);
    int dly;
    int dmax;
    bit got;
    dly  = 0;
    got  = 1'b0;
    dmax = (p == 0) ? D0 : 0;
    drive(p, a, w, s, d);
    push_exp(p, a, w, s, d);
    for (int k = 0; k < 40; k++) begin
      sample();
      if (obs_gnt(p)) begin
        got = 1'b1;
        break;
      end
      dly++;
      adv();
    end
    check({tag, "_granted"}, 64'(got), 64'd1);
    if (!got) begin
      void'(exp_q.pop_back());
      req[p] = 1'b0;
      adv();
      return;
    end
`ifdef MEM_RESP_RAND_STALL_EN
    check({tag, "_dly_le"}, 64'(dly <= dmax), 64'd1);
    if (p == 0 && dly < 16) seen[dly] = 1'b1;
`else
    check({tag, "_dly"}, 64'(dly), 64'(dmax));
`endif
    adv();
    req[p] = 1'b0;
  endtask

  // Leave port 0 in WAIT with req high; an immediate grant is accepted and retried.
  task automatic enter_wait(input logic [63:0] a, input logic w, input logic [63:0] d);
    for (int k = 0; k < 16; k++) begin
      drive(0, a, w, 8'hFF, d + 64'(k));
      sample();
      if (!gnt0) begin
        adv();
        return;
      end
      push_exp(0, a, w, 8'hFF, d + 64'(k));
      adv();
      req[0] = 1'b0;
      sample();
      adv();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; wen[p] = 1'b0; addr[p] = '0; wdata[p] = '0; strb[p] = '0;
      last_rd[p] = '0; pend[p] = 1'b0;
    end
    seen = '0;
    #1;
    check("rst_gnt0", 64'(gnt0), 64'd0);
    check("rst_err0", 64'(err0), 64'd0);
    check("rst_rd0", rd0, 64'd0);
    check("rst_gnt1", 64'(gnt1), 64'd0);
    check("rst_err1", 64'(err1), 64'd0);
    check("rst_rd1", rd1, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload words 0..15 of port 0
    for (int k = 0; k < 16; k++)
      do_req(0, BASE + 64'(8*k), 1'b1, 8'hFF, 64'h0101_0101_0000_0000 * 64'(k + 1), "preload");

    do_req(0, BASE + 64'h10, 1'b1, 8'hFF, 64'hDEAD_BEEF_0123_4567, "wr_10");
    do_req(0, BASE + 64'h10, 1'b0, 8'h00, 64'd0, "rd_10");
    idle(1);
    check("rd_10_value", rd0, 64'hDEAD_BEEF_0123_4567);

    do_req(0, BASE + 64'h20, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_ones");
    do_req(0, BASE + 64'h20, 1'b1, 8'h0F, 64'h1111_1111_2222_2222, "wr_strb");
    do_req(0, BASE + 64'h20, 1'b0, 8'h00, 64'd0, "rd_strb");
    idle(1);
    check("strb_merge", rd0, 64'hFFFF_FFFF_2222_2222);

    do_req(0, BASE, 1'b1, 8'hFF, 64'hA5A5_0000_1234_5678, "wr_0");
    do_req(0, BASE + 64'(1024*8), 1'b0, 8'h00, 64'd0, "rd_hi");
    sample();
    check("oor_hi_err", 64'(err0), 64'd1);
    check("oor_hi_rd", rd0, 64'd0);
    adv(); sample();
    check("oor_hi_err_pulse", 64'(err0), 64'd0);
    adv();
    do_req(0, BASE - 64'd8, 1'b0, 8'h00, 64'd0, "rd_lo");
    sample();
    check("oor_lo_err", 64'(err0), 64'd1);
    adv(); sample();
    check("oor_lo_err_pulse", 64'(err0), 64'd0);
    adv();
    do_req(0, BASE + 64'(1024*8), 1'b1, 8'hFF, 64'hFFFF_0000_FFFF_0000, "wr_oor");
    do_req(0, BASE, 1'b0, 8'h00, 64'd0, "rd_0");
    idle(1);
    check("no_wrap_write", rd0, 64'hA5A5_0000_1234_5678);

    // Withdrawn write must not reach the array
    enter_wait(BASE + 64'h10, 1'b1, 64'hBAD0_BAD0_BAD0_0000);
    req[0] = 1'b0;
    sample();
    check("withdraw_no_gnt", 64'(gnt0), 64'd0);
    adv(); sample();
    check("withdraw_no_gnt2", 64'(gnt0), 64'd0);
    adv();
    do_req(0, BASE + 64'h10, 1'b0, 8'h00, 64'd0, "rd_after_withdraw");
    idle(1);
    check("withdraw_keep", rd0, model[0][2]);

    // Asynchronous reset while waiting
    enter_wait(BASE + 64'h30, 1'b0, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", 64'(gnt0), 64'd0);
    check("midrst_err", 64'(err0), 64'd0);
    check("midrst_rd", rd0, 64'd0);
    req[0] = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    pend[0] = 1'b0;  pend[1] = 1'b0;
    sample();
    adv();
    rst = 1'b0;
    do_req(0, BASE + 64'h10, 1'b0, 8'h00, 64'd0, "post_rst_rd");

    // Back-to-back mixed traffic over the preloaded window
    for (int i = 0; i < NREQ; i++)
      do_req(0, BASE + 64'(8 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             8'($urandom), {$urandom, $urandom}, "sweep");
    idle(2);
`ifdef MEM_RESP_RAND_STALL_EN
    check("all_delays_seen", 64'(seen[3:0]), 64'hF);
`endif

    // Zero-delay port: one transaction per cycle
    for (int k = 0; k < 4; k++)
      do_req(1, BASE + 64'(8 * (40 + k)), 1'b1, 8'hFF, 64'hC0DE_0000_0000_0000 + 64'(k), "p1_wr");
    for (int k = 0; k < 4; k++) begin
      drive(1, BASE + 64'(8 * (40 + k)), 1'b0, 8'h00, 64'd0);
      push_exp(1, BASE + 64'(8 * (40 + k)), 1'b0, 8'h00, 64'd0);
      sample();
      check("stream_gnt", 64'(gnt1), 64'd1);
      adv();
    end
    req[1] = 1'b0;
    idle(2);
    check("stream_last", rd1, 64'hC0DE_0000_0000_0003);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
